// File: rtl/bp_update_ctrl_pkg.sv
// Shared types for the branch-predictor update controller.
// Branch type codes, FSM states and the queued update entry.
package bp_update_ctrl_pkg;

  localparam int BHR_W = 4;

  localparam logic [1:0] BR_DIRECT = 2'b00;
  localparam logic [1:0] BR_CALL   = 2'b01;
  localparam logic [1:0] BR_RET    = 2'b10;
  localparam logic [1:0] BR_IND    = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      target;
    logic [1:0]       btype;
    logic             taken;
    logic [BHR_W-1:0] bhr;
  } upd_entry_t;

endpackage

// File: rtl/bp_update_ctrl_if.sv
// Commit, fetch-arbitration and table-update signals of bp_update_ctrl.
// master = commit/fetch side, slave = the controller.
interface bp_update_ctrl_if #(
  parameter int IDX_W = 7
);
  import bp_update_ctrl_pkg::*;

  logic             cm0_valid;
  logic [31:0]      cm0_pc;
  logic [31:0]      cm0_target;
  logic [1:0]       cm0_type;
  logic             cm0_taken;
  logic [BHR_W-1:0] cm0_bhr;
  logic             cm1_valid;
  logic [31:0]      cm1_pc;
  logic [31:0]      cm1_target;
  logic [1:0]       cm1_type;
  logic             cm1_taken;
  logic [BHR_W-1:0] cm1_bhr;
  logic             cm_ready;
  logic             fetch_rd;
  logic             fetch_stall;
  logic             bp_clear;
  logic             upd_en;
  logic             upd_init;
  logic [IDX_W-1:0] upd_index;
  logic [31:0]      upd_pc;
  logic [31:0]      upd_target;
  logic [1:0]       upd_type;
  logic             upd_taken;
  logic [BHR_W-1:0] upd_bhr;
  logic             busy;

  modport master (
    output cm0_valid, cm0_pc, cm0_target,
    output cm0_type, cm0_taken, cm0_bhr,
    output cm1_valid, cm1_pc, cm1_target,
    output cm1_type, cm1_taken, cm1_bhr,
    output fetch_rd, bp_clear,
    input  cm_ready, fetch_stall,
    input  upd_en, upd_init, upd_index,
    input  upd_pc, upd_target, upd_type,
    input  upd_taken, upd_bhr, busy
  );

  modport slave (
    input  cm0_valid, cm0_pc, cm0_target,
    input  cm0_type, cm0_taken, cm0_bhr,
    input  cm1_valid, cm1_pc, cm1_target,
    input  cm1_type, cm1_taken, cm1_bhr,
    input  fetch_rd, bp_clear,
    output cm_ready, fetch_stall,
    output upd_en, upd_init, upd_index,
    output upd_pc, upd_target, upd_type,
    output upd_taken, upd_bhr, busy
  );

endinterface

// File: rtl/bp_upd_fifo.sv
// 2-write / 1-read circular FIFO of update entries.
// Ports: we0/d0, we1/d1 (d1 lands after d0), pop, flush; head/count/empty/full.
module bp_upd_fifo
  import bp_update_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          we0,
  input  upd_entry_t    d0,
  input  logic          we1,
  input  upd_entry_t    d1,
  input  logic          pop,
  output upd_entry_t    head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  upd_entry_t    mem_q [DEPTH];
  upd_entry_t    mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (we0) mem_d[wr_q] = d0;
      // slot 1 packs behind slot 0 only when slot 0 was written
      if (we1) mem_d[wr_q + PW'(we0)] = d1;
      wr_d  = wr_q + PW'(we0) + PW'(we1);
      rd_d  = rd_q + PW'(pop);
      cnt_d = cnt_q + CW'(we0) + CW'(we1)
            - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch-predictor update sequencer: table clear sweep, commit FIFO, port arbiter.
// Ports: clk, resetn (sync, active-low), bus (slave side of bp_update_ctrl_if).
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int IDX_W      = 7,
  parameter int STARVE_MAX = 3,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int SW = $clog2(STARVE_MAX + 1)
) (
  input logic         clk,
  input logic         resetn,
  bp_update_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             upd_v_q, upd_v_d;
  upd_entry_t       upd_q, upd_d;

  upd_entry_t    d0, d1, head, out;
  logic [CW-1:0] cnt;
  logic          empty, full;
  logic          flush, we0, we1, grant;
  logic          ready, init;

  assign d0 = '{bus.cm0_pc, bus.cm0_target,
                bus.cm0_type, bus.cm0_taken,
                bus.cm0_bhr};
  assign d1 = '{bus.cm1_pc, bus.cm1_target,
                bus.cm1_type, bus.cm1_taken,
                bus.cm1_bhr};

  bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .we0    (we0),
    .d0     (d0),
    .we1    (we1),
    .d1     (d1),
    .pop    (grant),
    .head   (head),
    .count  (cnt),
    .empty  (empty),
    .full   (full)
  );

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    starve_d = starve_q;
    upd_v_d  = 1'b0;
    upd_d    = upd_q;
    flush    = 1'b0;
    we0      = 1'b0;
    we1      = 1'b0;
    grant    = 1'b0;
    ready    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        sweep_d  = sweep_q + 1'b1;
        starve_d = '0;
        if (&sweep_q) state_d = ST_RUN;
        if (bus.bp_clear) begin
          sweep_d = '0;
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        ready = (cnt <= CW'(DEPTH - 2));
        if (bus.bp_clear) begin
          // no grant here so nothing but
          // sweep writes follow the clear
          flush    = 1'b1;
          sweep_d  = '0;
          starve_d = '0;
          state_d  = ST_INIT;
        end else begin
          we0 = ready & bus.cm0_valid;
          we1 = ready & bus.cm1_valid;
          if (empty) begin
            starve_d = '0;
          end else if (!bus.fetch_rd || full ||
                       starve_q == SW'(STARVE_MAX)) begin
            grant    = 1'b1;
            starve_d = '0;
            upd_v_d  = 1'b1;
            upd_d    = head;
          end else begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_INIT;
      sweep_q  <= '0;
      starve_q <= '0;
      upd_v_q  <= 1'b0;
      upd_q    <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      starve_q <= starve_d;
      upd_v_q  <= upd_v_d;
      upd_q    <= upd_d;
    end
  end

  // outputs are gated by resetn so they read
  // zero while reset is held, even before the
  // first reset edge has been taken
  always_comb begin
    init            = (state_q == ST_INIT);
    bus.busy        = !resetn | init;
    bus.fetch_stall = !resetn | init |
                      (bus.fetch_rd & grant);
    bus.cm_ready    = resetn & ready;
    bus.upd_en      = resetn & (init | upd_v_q);
    bus.upd_init    = resetn & init;
    bus.upd_index   = (resetn & init) ? sweep_q : '0;
    out = (resetn & !init & upd_v_q) ? upd_q : '0;
    bus.upd_pc      = out.pc;
    bus.upd_target  = out.target;
    bus.upd_type    = out.btype;
    bus.upd_taken   = out.taken;
    bus.upd_bhr     = out.bhr;
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl (DEPTH=4, IDX_W=3, STARVE_MAX=3).
// Drives after posedge, samples on negedge.
module tb_bp_update_ctrl;
  import bp_update_ctrl_pkg::*;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  bp_update_ctrl_if #(.IDX_W(3)) bus ();

  bp_update_ctrl #(
    .DEPTH      (4),
    .IDX_W      (3),
    .STARVE_MAX (3)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.cm0_valid  = 1'b0;
    bus.cm0_pc     = '0;
    bus.cm0_target = '0;
    bus.cm0_type   = '0;
    bus.cm0_taken  = 1'b0;
    bus.cm0_bhr    = '0;
    bus.cm1_valid  = 1'b0;
    bus.cm1_pc     = '0;
    bus.cm1_target = '0;
    bus.cm1_type   = '0;
    bus.cm1_taken  = 1'b0;
    bus.cm1_bhr    = '0;
    bus.fetch_rd   = 1'b0;
    bus.bp_clear   = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] a, e;
    resetn = 1'b0;
    clr_inputs();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({bus.upd_en, bus.upd_init, bus.cm_ready,
         bus.upd_index, bus.upd_pc} !== '0) begin
      failures++;
      $display("FAIL reset_outs en=%b init=%b rdy=%b idx=%0d pc=%h exp all 0",
               bus.upd_en, bus.upd_init, bus.cm_ready,
               bus.upd_index, bus.upd_pc);
    end
    checks++;
    if ({bus.busy, bus.fetch_stall} !== 2'b11) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=11",
               {bus.busy, bus.fetch_stall});
    end
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = {bus.upd_en, bus.upd_init, bus.upd_index,
           bus.cm_ready, bus.busy};
      e = {1'b1, 1'b1, 3'(i), 1'b0, 1'b1};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL sweep_%0d got=%b exp=%b", i, a, e);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.cm_ready, bus.upd_en,
         bus.fetch_stall} !== 4'b0100) begin
      failures++;
      $display("FAIL run_entry got=%b exp=0100",
               {bus.busy, bus.cm_ready, bus.upd_en,
                bus.fetch_stall});
    end
  endtask

  task automatic test_dual();
    logic [71:0] a, e;
    tick();
    bus.cm0_valid  = 1'b1;
    bus.cm0_pc     = 32'h100;
    bus.cm0_target = 32'h5000;
    bus.cm0_type   = BR_CALL;
    bus.cm0_taken  = 1'b1;
    bus.cm0_bhr    = 4'hA;
    bus.cm1_valid  = 1'b1;
    bus.cm1_pc     = 32'h104;
    bus.cm1_target = 32'h6000;
    bus.cm1_type   = BR_IND;
    bus.cm1_taken  = 1'b0;
    bus.cm1_bhr    = 4'h3;
    @(negedge clk);
    checks++;
    if (bus.cm_ready !== 1'b1) begin
      failures++;
      $display("FAIL dual_ready got=%b exp=1", bus.cm_ready);
    end
    tick();
    bus.cm0_valid = 1'b0;
    bus.cm1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.upd_en !== 1'b0) begin
      failures++;
      $display("FAIL dual_latency got=%b exp=0", bus.upd_en);
    end
    tick();
    @(negedge clk);
    a = {bus.upd_en, bus.upd_init, bus.upd_pc,
         bus.upd_target, bus.upd_type, bus.upd_taken,
         bus.upd_bhr};
    e = {1'b1, 1'b0, 32'h100, 32'h5000, BR_CALL,
         1'b1, 4'hA};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL dual_first got=%h exp=%h", a, e);
    end
    tick();
    @(negedge clk);
    a = {bus.upd_en, bus.upd_init, bus.upd_pc,
         bus.upd_target, bus.upd_type, bus.upd_taken,
         bus.upd_bhr};
    e = {1'b1, 1'b0, 32'h104, 32'h6000, BR_IND,
         1'b0, 4'h3};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL dual_second got=%h exp=%h", a, e);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.upd_en !== 1'b0) begin
      failures++;
      $display("FAIL dual_drained got=%b exp=0", bus.upd_en);
    end
    tick();
    bus.cm1_valid  = 1'b1;
    bus.cm1_pc     = 32'h200;
    bus.cm1_target = 32'h7000;
    bus.cm1_type   = BR_RET;
    bus.cm1_taken  = 1'b1;
    bus.cm1_bhr    = 4'h5;
    tick();
    bus.cm1_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({bus.upd_en, bus.upd_pc, bus.upd_type} !==
        {1'b1, 32'h200, BR_RET}) begin
      failures++;
      $display("FAIL slot1_only en=%b pc=%h type=%b exp en=1 pc=200 type=10",
               bus.upd_en, bus.upd_pc, bus.upd_type);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.upd_en !== 1'b0) begin
      failures++;
      $display("FAIL slot1_alone got=%b exp=0", bus.upd_en);
    end
  endtask

  task automatic test_starve();
    tick();
    bus.cm0_valid = 1'b1;
    bus.cm0_pc    = 32'h300;
    bus.fetch_rd  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.fetch_stall !== 1'b0) begin
      failures++;
      $display("FAIL starve_empty got=%b exp=0", bus.fetch_stall);
    end
    tick();
    bus.cm0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.fetch_stall, bus.upd_en} !== 2'b00) begin
        failures++;
        $display("FAIL starve_fetch_%0d got=%b exp=00",
                 k, {bus.fetch_stall, bus.upd_en});
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({bus.fetch_stall, bus.upd_en} !== 2'b10) begin
      failures++;
      $display("FAIL starve_force got=%b exp=10",
               {bus.fetch_stall, bus.upd_en});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.upd_en, bus.upd_pc, bus.fetch_stall} !==
        {1'b1, 32'h300, 1'b0}) begin
      failures++;
      $display("FAIL starve_issue en=%b pc=%h stall=%b exp 1 300 0",
               bus.upd_en, bus.upd_pc, bus.fetch_stall);
    end
    bus.fetch_rd = 1'b0;
  endtask

  task automatic test_full();
    logic [33:0] a, e;
    tick();
    bus.fetch_rd  = 1'b1;
    bus.cm0_valid = 1'b1;
    bus.cm0_pc    = 32'h400;
    bus.cm1_valid = 1'b1;
    bus.cm1_pc    = 32'h404;
    tick();
    bus.cm0_pc = 32'h408;
    bus.cm1_pc = 32'h40C;
    @(negedge clk);
    checks++;
    if ({bus.cm_ready, bus.fetch_stall} !== 2'b10) begin
      failures++;
      $display("FAIL full_cnt2 got=%b exp=10",
               {bus.cm_ready, bus.fetch_stall});
    end
    tick();
    bus.cm0_valid = 1'b0;
    bus.cm1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cm_ready, bus.fetch_stall, bus.upd_en} !==
        3'b010) begin
      failures++;
      $display("FAIL full_force got=%b exp=010",
               {bus.cm_ready, bus.fetch_stall, bus.upd_en});
    end
    tick();
    bus.fetch_rd = 1'b0;
    @(negedge clk);
    a = {bus.cm_ready, bus.upd_en, bus.upd_pc};
    e = {1'b0, 1'b1, 32'h400};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL full_cnt3 got=%h exp=%h", a, e);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      @(negedge clk);
      a = {bus.cm_ready, bus.upd_en, bus.upd_pc};
      e = {1'b1, 1'b1, 32'h400 + 32'(4 * k)};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL full_drain_%0d got=%h exp=%h", k, a, e);
      end
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.upd_en !== 1'b0) begin
      failures++;
      $display("FAIL full_empty got=%b exp=0", bus.upd_en);
    end
  endtask

  task automatic test_clear();
    logic [37:0] a, e;
    tick();
    bus.fetch_rd  = 1'b1;
    bus.cm0_valid = 1'b1;
    bus.cm0_pc    = 32'h500;
    bus.cm1_valid = 1'b1;
    bus.cm1_pc    = 32'h504;
    tick();
    bus.cm0_pc    = 32'h508;
    bus.cm1_valid = 1'b0;
    tick();
    bus.cm0_valid = 1'b0;
    bus.bp_clear  = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.upd_en, bus.fetch_stall, bus.busy} !== 3'b000) begin
      failures++;
      $display("FAIL clear_cycle got=%b exp=000",
               {bus.upd_en, bus.fetch_stall, bus.busy});
    end
    tick();
    bus.bp_clear  = 1'b0;
    bus.fetch_rd  = 1'b0;
    bus.cm0_valid = 1'b1;
    bus.cm0_pc    = 32'h900;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = {bus.upd_en, bus.upd_init, bus.upd_index,
           bus.cm_ready, bus.upd_pc};
      e = {1'b1, 1'b1, 3'(i), 1'b0, 32'h0};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL clear_sweep_%0d got=%h exp=%h", i, a, e);
      end
      tick();
    end
    bus.cm0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.cm_ready, bus.upd_en} !== 3'b010) begin
      failures++;
      $display("FAIL clear_run got=%b exp=010",
               {bus.busy, bus.cm_ready, bus.upd_en});
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (bus.upd_en !== 1'b0) begin
        failures++;
        $display("FAIL clear_flushed_%0d got=%b exp=0",
                 k, bus.upd_en);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick();
    bus.bp_clear = 1'b1;
    tick();
    bus.bp_clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.upd_init, bus.upd_index} !== {1'b1, 3'(i)}) begin
        failures++;
        $display("FAIL mid_pre_%0d got=%b exp=%b", i,
                 {bus.upd_init, bus.upd_index}, {1'b1, 3'(i)});
      end
      tick();
    end
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.upd_en, bus.upd_init, bus.upd_index,
           bus.cm_ready, bus.busy, bus.fetch_stall} !==
          7'b0000011) begin
        failures++;
        $display("FAIL mid_reset_%0d got=%b exp=0000011", k,
                 {bus.upd_en, bus.upd_init, bus.upd_index,
                  bus.cm_ready, bus.busy, bus.fetch_stall});
      end
      tick();
    end
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.upd_en, bus.upd_init, bus.upd_index} !==
          {1'b1, 1'b1, 3'(i)}) begin
        failures++;
        $display("FAIL mid_restart_%0d got=%b exp=%b", i,
                 {bus.upd_en, bus.upd_init, bus.upd_index},
                 {1'b1, 1'b1, 3'(i)});
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_done got=%b exp=0", bus.busy);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    clr_inputs();
    test_reset();
    test_dual();
    test_starve();
    test_full();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
Sequencer and arbiter for the branch-predictor table port. Accepts up to two resolved branches per cycle from commit and buffers them in order in a FIFO. Drains one update per cycle into the history, BTB and target-cache tables, sharing the single table port with fetch-side prediction reads. Also runs the table-clear sweep after reset and on a software clear.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >=4)
IDX_W, 7, table index width; the sweep covers 2^IDX_W entries
BHR_W, 4, branch history register width
STARVE_MAX, 3, maximum consecutive cycles an update may lose to fetch

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
cm0_valid  in  1  commit slot 0 carries a resolved branch
cm0_pc  in  32  branch pc
cm0_target  in  32  resolved target
cm0_type  in  2  00 direct, 01 call, 10 return, 11 indirect
cm0_taken  in  1  resolved direction
cm0_bhr  in  BHR_W  history used at prediction
cm1_valid/cm1_pc/cm1_target/cm1_type/cm1_taken/cm1_bhr  in  same widths  commit slot 1 (younger)
cm_ready  out  1  both slots may be offered this cycle
fetch_rd  in  1  fetch wants the table port this cycle
fetch_stall  out  1  fetch denied the port
bp_clear  in  1  software request to clear the tables
upd_en  out  1  table write strobe
upd_init  out  1  write is a clear-sweep write
upd_index  out  IDX_W  sweep index (valid when upd_init=1)
upd_pc/upd_target/upd_type/upd_taken/upd_bhr  out  as slot  update payload
busy  out  1  controller is in the INIT state

Behaviour:
- Reset: clk and resetn as decided (one clock; synchronous, active-low reset).
  - State goes to INIT, FIFO is emptied, sweep and starve counters cleared.
  - All outputs are 0 during reset, except busy=1 and fetch_stall=1.
- State INIT:
  - Each cycle drives upd_en=1, upd_init=1, upd_index=sweep_cnt, then increments sweep_cnt.
  - Index 0 is driven in the first cycle after resetn rises.
  - After index 2^IDX_W-1 the controller moves to RUN.
  - In INIT: cm_ready=0, fetch_stall=1, busy=1, and the payload outputs are 0.
- State RUN:
  - cm_ready = (DEPTH - count >= 2), computed combinationally from the registered count.
  - Enqueue happens when cm_ready=1. Slot 0 is written before slot 1. Either slot may be valid alone; an invalid slot is skipped and leaves no gap.
  - Slots offered while cm_ready=0 are ignored; the producer holds them.
  - Grant rule:
    - FIFO non-empty and fetch_rd=0: the update wins.
    - FIFO non-empty and fetch_rd=1: fetch wins (fetch_stall=0) and starve_cnt increments.
    - When starve_cnt==STARVE_MAX, or the FIFO is full, the update wins, fetch_stall=1, and starve_cnt clears.
    - starve_cnt also clears on any update grant.
  - On an update grant the head is popped. upd_en=1 and the payload are registered and appear the cycle after the grant (1-cycle latency); upd_init=0.
  - Simultaneous enqueue (up to 2) and pop: count = count + n_enq - 1. The pointers wrap modulo DEPTH.
  - FIFO empty: upd_en=0 and fetch always wins.
- bp_clear (RUN state, sampled high):
  - Next cycle: FIFO flushed, sweep_cnt=0, state INIT. Any pending enqueue that cycle is dropped.
  - bp_clear while in INIT restarts the sweep at 0.
- Reset mid-sweep or mid-drain: reset wins unconditionally. The sweep restarts from index 0 after resetn rises.

Decomposition:
- Shared package: branch type constants (BR_DIRECT=2'b00, BR_CALL=2'b01, BR_RET=2'b10, BR_IND=2'b11), the state encoding (ST_INIT, ST_RUN), and the update-entry struct {pc, target, type, taken, bhr}.
- Sub-module bp_upd_fifo: 2-write, 1-read circular FIFO with count, flush and wrapping pointers.
- Arbitration, the starve counter and the FSM stay in the top.

Test Plan:
- Reset sweep (IDX_W=3): release resetn -> upd_init=1 with upd_index 0..7 on 8 consecutive cycles; then busy=0 and cm_ready=1 on cycle 9.
- Dual commit with fetch_rd=0:
  - Stimulus: slot0 pc=0x100, slot1 pc=0x104 in one cycle.
  - Response: upd_pc=0x100 then 0x104 on the next two cycles, upd_en=1 on both.
  - A slot1-only commit of pc=0x200 is drained alone.
- Starvation (STARVE_MAX=3):
  - Stimulus: one entry queued, fetch_rd held 1.
  - Response: fetch_stall=0 for 3 cycles; on the 4th, fetch_stall=1 and the update issues the following cycle.
- Full (DEPTH=4):
  - Stimulus: fetch_rd=1 held, commit two pairs.
  - Response: cm_ready falls to 0 when count reaches 3. The update is forced at count=4 with fetch_stall=1 that cycle.
- bp_clear with 3 entries queued -> no further upd_init=0 writes; sweep 0..2^IDX_W-1 follows; FIFO empty afterwards.
- Reset asserted at sweep index 5 -> outputs zero while low; sweep restarts at index 0 after release.
